pe_shift_sum: RTL and testbench
===============================

# pe_shift_sum

Shift-and-sum accumulation stage of the PE datapath. It sits directly downstream of the multiplier stage and consumes the `SSctl` control bundle produced by the PE datapath controller. Each accepted partial product is shifted by the bit-serial weight/input significance and accumulated into a running sum. A completed pixel sum is either:
- written back to the psum pad (intermediate rows), or
- handed downstream through a rdy/ack port (last row).

## Interface
Parameters:
- `PRODWD`, 16: signed partial-product width from the multiplier stage.
- `PSUMWD`, 32: accumulator and psum pad data width.
- `SHTWD`, 5: shift-amount width.
- `CNTWD`, 8: width of the completed-pixel counter.

Ports:
- `i_clk` in 1: clock. One clock domain.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_Prod_rdy` in 1: product valid (source side of rdy/ack).
- `o_Prod_ack` out 1: product accepted.
- `i_prod` in `PRODWD`: signed partial product.
- `i_resetsum` in 1: start a new sum with this term.
- `i_psumread` in 1: reload the sum from the psum pad.
- `i_psumwrite` in 1: this term completes the pixel.
- `i_lstrow` in 1: the completed pixel is final and goes out, not to the pad.
- `i_psum_mode` in 1: 0 = D32, 1 = D16.
- `i_sht_num` in `SHTWD`: left-shift amount.
- `i_ppad_rdata` in `PSUMWD`: psum pad read data, valid in the same cycle as `i_psumread`.
- `o_ppad_write` out 1: psum pad write strobe.
- `o_ppad_wdata` out `PSUMWD`: psum pad write data.
- `o_Out_rdy` out 1: final sum valid.
- `i_Out_ack` in 1: downstream accepts the final sum.
- `o_out` out `PSUMWD`: final sum.
- `o_pixcnt` out `CNTWD`: number of pixels completed since reset.
- `o_busy` out 1: high when the accumulator holds a partial sum or the output is pending.

## Operation
- Transfer: a product is transferred when `i_Prod_rdy && o_Prod_ack`. All control inputs are sampled only on a transfer.
- Term: `term = sext(i_prod, PSUMWD) << i_sht_num`. Bits shifted beyond `PSUMWD` are discarded.
- Sum source, by priority:
  - `i_resetsum`: `sum = term`.
  - else `i_psumread`: `sum = i_ppad_rdata + term`.
  - else: `sum = acc + term`.
  - All additions are modulo 2^PSUMWD.
- D16 mode: before `term` is added, `i_ppad_rdata` is taken as its low 16 bits sign-extended. A completed result is saturated to the range [-32768, 32767] and sign-extended to `PSUMWD`. D32 mode: no saturation; the result wraps.
- Pixel completion (`i_psumwrite`):
  - with `!i_lstrow`: the result goes to the pad write register; `acc` is cleared.
  - with `i_lstrow`: the result goes to the output register; `acc` is cleared.
- Without `i_psumwrite`: `acc <= sum`.
- FSM states: IDLE, ACC, HOLD.
  - IDLE → ACC on a transfer without `i_psumwrite`.
  - ACC → IDLE on a completing transfer with `!i_lstrow`.
  - Any state → HOLD on a completing transfer with `i_lstrow`.
  - HOLD → IDLE on `i_Out_ack`, or HOLD → ACC if a non-completing transfer occurs in the same cycle.
  - A transfer in IDLE with `i_psumwrite` and `!i_lstrow` stays IDLE.
- `o_busy = (state != IDLE)`.
- Ack rule: `o_Prod_ack = !o_Out_rdy || i_Out_ack`. This is a one-entry output register; a simultaneous drain and refill is allowed.
- `o_pixcnt` increments on every completion (pad write or final output) and wraps at 2^CNTWD.

## Timing
- Reset values: `o_Prod_ack` = 1. All other outputs = 0. `acc` = 0, state = IDLE.
- Pad write latency: `o_ppad_write` and `o_ppad_wdata` are registered. They are asserted for exactly one cycle, the cycle after the completing transfer. There is no backpressure from the pad.
- Output handshake:
  - `o_Out_rdy` rises the cycle after a completing transfer with `i_lstrow`.
  - `o_out` holds stable until `i_Out_ack`; `o_Out_rdy` falls the cycle after the ack unless a new final result is loaded in the same cycle.
- While `o_Out_rdy && !i_Out_ack`: `o_Prod_ack` = 0 and `acc` is frozen.
- `o_pixcnt` updates the cycle after completion.
- `i_resetsum` and `i_psumread` asserted together: `i_resetsum` wins and pad data is ignored.
- Reset mid-operation: state returns to IDLE at once, a pending output is dropped, and outputs return to their reset values asynchronously.

## Test plan
- D32 accumulate:
  - Stimulus: products 3 (sht 0, resetsum), 5 (sht 2), −1 (sht 4, psumwrite).
  - Required: one-cycle `o_ppad_write` with wdata 7; `o_pixcnt` = 1; state returns to IDLE.
- Pad reload:
  - Stimulus: `i_psumread` with rdata 100 and product 2 (sht 1), followed by a completing product 0.
  - Required: wdata 104.
- D16 saturation:
  - Stimulus: resetsum product 0x4000 sht 1, then completing product 1 sht 0.
  - Required: wdata 0x00007FFF.
  - Repeat with negative values; required wdata 0xFFFF8000.
- Last row with backpressure:
  - Stimulus: completing transfer with `i_lstrow` and result 42; hold `i_Out_ack` low for 3 cycles.
  - Required: `o_out` = 42 stable; `o_Prod_ack` = 0 for those 3 cycles; after the ack, `o_Out_rdy` falls and `o_Prod_ack` = 1.
- Simultaneous drain and refill:
  - Stimulus: `i_Out_ack` in the same cycle as a new completing last-row transfer with result 9.
  - Required: `o_Out_rdy` stays 1 and `o_out` changes to 9 the next cycle.
- Reset mid-HOLD:
  - Stimulus: assert `i_rst` low while `o_Out_rdy` = 1.
  - Required: `o_Out_rdy`, `o_busy` and `o_pixcnt` go to 0 immediately; `o_Prod_ack` = 1.

Source files
------------

// File: rtl/pe_shift_sum.sv
// Shift-and-sum accumulation stage: shifts each partial product by its bit-serial
// significance, accumulates it, and retires finished pixels to the psum pad or downstream.
module pe_shift_sum #(
  parameter int PRODWD = 16,
  parameter int PSUMWD = 32,
  parameter int SHTWD  = 5,
  parameter int CNTWD  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_Prod_rdy,
  output logic              o_Prod_ack,
  input  logic [PRODWD-1:0] i_prod,
  input  logic              i_resetsum,
  input  logic              i_psumread,
  input  logic              i_psumwrite,
  input  logic              i_lstrow,
  input  logic              i_psum_mode,
  input  logic [SHTWD-1:0]  i_sht_num,
  input  logic [PSUMWD-1:0] i_ppad_rdata,
  output logic              o_ppad_write,
  output logic [PSUMWD-1:0] o_ppad_wdata,
  output logic              o_Out_rdy,
  input  logic              i_Out_ack,
  output logic [PSUMWD-1:0] o_out,
  output logic [CNTWD-1:0]  o_pixcnt,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic signed [PSUMWD-1:0] SAT_MAX = PSUMWD'(32'sd32767);
  localparam logic signed [PSUMWD-1:0] SAT_MIN = PSUMWD'(-32'sd32768);

  state_t                   r_state;
  logic [PSUMWD-1:0]        r_acc;
  logic                     r_ppad_write;
  logic [PSUMWD-1:0]        r_ppad_wdata;
  logic                     r_out_rdy;
  logic [PSUMWD-1:0]        r_out;
  logic [CNTWD-1:0]         r_pixcnt;

  logic                     w_xfer;
  logic signed [PSUMWD-1:0] w_prod_ext;
  logic signed [PSUMWD-1:0] w_term;
  logic signed [PSUMWD-1:0] w_pad;
  logic signed [PSUMWD-1:0] w_base;
  logic signed [PSUMWD-1:0] w_sum;
  logic signed [PSUMWD-1:0] w_result;

  // One-entry output register: a waiting final sum blocks new products unless it drains now.
  assign o_Prod_ack = !r_out_rdy || i_Out_ack;
  assign w_xfer     = i_Prod_rdy && o_Prod_ack;

  assign w_prod_ext = {{(PSUMWD-PRODWD){i_prod[PRODWD-1]}}, i_prod};
  assign w_term     = w_prod_ext << i_sht_num;
  assign w_pad      = i_psum_mode ? {{(PSUMWD-16){i_ppad_rdata[15]}}, i_ppad_rdata[15:0]}
                                  : i_ppad_rdata;

  always_comb begin
    w_base = r_acc;
    if (i_resetsum) begin
      w_base = '0;
    end else if (i_psumread) begin
      w_base = w_pad;
    end
  end

  assign w_sum = w_base + w_term;

  always_comb begin
    w_result = w_sum;
    if (i_psum_mode) begin
      if (w_sum > SAT_MAX) begin
        w_result = SAT_MAX;
      end else if (w_sum < SAT_MIN) begin
        w_result = SAT_MIN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_ppad_write <= 1'b0;
      r_ppad_wdata <= '0;
      r_out_rdy    <= 1'b0;
      r_out        <= '0;
      r_pixcnt     <= '0;
    end else begin
      r_ppad_write <= 1'b0;
      if (r_out_rdy && i_Out_ack) begin
        r_out_rdy <= 1'b0;
      end
      if (w_xfer) begin
        if (i_psumwrite) begin
          r_acc    <= '0;
          r_pixcnt <= r_pixcnt + CNTWD'(1);
          if (i_lstrow) begin
            r_out     <= w_result;
            r_out_rdy <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_ppad_write <= 1'b1;
            r_ppad_wdata <= w_result;
            r_state      <= S_IDLE;
          end
        end else begin
          r_acc   <= w_sum;
          r_state <= S_ACC;
        end
      end else if (r_state == S_HOLD && i_Out_ack) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_ppad_write = r_ppad_write;
  assign o_ppad_wdata = r_ppad_wdata;
  assign o_Out_rdy    = r_out_rdy;
  assign o_out        = r_out;
  assign o_pixcnt     = r_pixcnt;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pe_shift_sum.sv
// Scoreboard bench for pe_shift_sum: directed scenarios plus randomized transfers
// checked against an arithmetic reference model.
module tb_pe_shift_sum;
  localparam int PRODWD = 16;
  localparam int PSUMWD = 32;
  localparam int SHTWD  = 5;
  localparam int CNTWD  = 8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_Prod_rdy = 1'b0;
  logic              o_Prod_ack;
  logic [PRODWD-1:0] i_prod = '0;
  logic              i_resetsum = 1'b0;
  logic              i_psumread = 1'b0;
  logic              i_psumwrite = 1'b0;
  logic              i_lstrow = 1'b0;
  logic              i_psum_mode = 1'b0;
  logic [SHTWD-1:0]  i_sht_num = '0;
  logic [PSUMWD-1:0] i_ppad_rdata = '0;
  logic              o_ppad_write;
  logic [PSUMWD-1:0] o_ppad_wdata;
  logic              o_Out_rdy;
  logic              i_Out_ack;
  logic [PSUMWD-1:0] o_out;
  logic [CNTWD-1:0]  o_pixcnt;
  logic              o_busy;

  pe_shift_sum #(.PRODWD(PRODWD), .PSUMWD(PSUMWD), .SHTWD(SHTWD), .CNTWD(CNTWD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_Prod_rdy(i_Prod_rdy), .o_Prod_ack(o_Prod_ack), .i_prod(i_prod),
    .i_resetsum(i_resetsum), .i_psumread(i_psumread), .i_psumwrite(i_psumwrite),
    .i_lstrow(i_lstrow), .i_psum_mode(i_psum_mode), .i_sht_num(i_sht_num),
    .i_ppad_rdata(i_ppad_rdata), .o_ppad_write(o_ppad_write), .o_ppad_wdata(o_ppad_wdata),
    .o_Out_rdy(o_Out_rdy), .i_Out_ack(i_Out_ack), .o_out(o_out),
    .o_pixcnt(o_pixcnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] pad_q[$];
  logic [31:0] out_q[$];
  longint      acc_m = 0;
  int          pix_m = 0;
  bit          ack_rand  = 1'b0;
  bit          ack_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: term = prod * 2^sht, everything modulo 2^32.
  function automatic logic [31:0] model_sum(input logic [15:0] p, input int sht, input bit rs,
                                            input bit pr, input logic [31:0] rd, input bit d16);
    longint      term;
    longint      base;
    logic [63:0] s;
    term = longint'($signed(p));
    for (int k = 0; k < sht; k++) term = term * 2;
    if (rs)       base = 0;
    else if (pr)  base = d16 ? longint'($signed(rd[15:0])) : longint'(rd);
    else          base = acc_m;
    s = 64'(base + term);
    return s[31:0];
  endfunction

  task automatic xfer(input logic [15:0] p, input int sht, input bit rs, input bit pr,
                      input bit pw, input bit lst, input bit d16, input logic [31:0] rd);
    int          waited;
    bit          got;
    logic [31:0] s;
    logic [31:0] r;
    waited = 0;
    got    = 1'b0;
    i_Prod_rdy = 1'b1; i_prod = p; i_sht_num = SHTWD'(sht);
    i_resetsum = rs; i_psumread = pr; i_psumwrite = pw; i_lstrow = lst;
    i_psum_mode = d16; i_ppad_rdata = rd;
    while (!got && waited < 200) begin
      @(negedge i_clk);
      if (o_Prod_ack) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_total++;
      $display("FAIL xfer_timeout: o_Prod_ack stayed 0 for %0d cycles, expected 1", waited);
    end else begin
      s = model_sum(p, sht, rs, pr, rd, d16);
      if (pw) begin
        r = s;
        if (d16) begin
          if ($signed(s) > 32767)       r = 32'h0000_7FFF;
          else if ($signed(s) < -32768) r = 32'hFFFF_8000;
        end
        if (lst) out_q.push_back(r);
        else     pad_q.push_back(r);
        acc_m = 0;
        pix_m++;
      end else begin
        acc_m = longint'(s);
      end
    end
    @(posedge i_clk); #1;
    i_Prod_rdy = 1'b0; i_resetsum = 1'b0; i_psumread = 1'b0;
    i_psumwrite = 1'b0; i_lstrow = 1'b0;
  endtask

  // Downstream consumer: settles after the driver so negedge sampling sees a stable ack.
  initial begin
    i_Out_ack = 1'b0;
    forever begin
      @(posedge i_clk); #2;
      i_Out_ack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_force;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pad write or an accepted output.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        if (o_ppad_write) begin
          if (pad_q.size() == 0) begin
            n_total++;
            $display("FAIL pad_unexpected: got write 0x%0h, expected no write", o_ppad_wdata);
          end else begin
            check("pad_wdata", 64'(o_ppad_wdata), 64'(pad_q.pop_front()));
          end
        end
        if (o_Out_rdy && i_Out_ack) begin
          if (out_q.size() == 0) begin
            n_total++;
            $display("FAIL out_unexpected: got out 0x%0h, expected no output", o_out);
          end else begin
            check("out_data", 64'(o_out), 64'(out_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_prod_ack", 64'(o_Prod_ack), 64'd1);
    check("rst_out_rdy",  64'(o_Out_rdy),  64'd0);
    check("rst_ppad_wr",  64'(o_ppad_write), 64'd0);
    check("rst_ppad_wd",  64'(o_ppad_wdata), 64'd0);
    check("rst_out",      64'(o_out),      64'd0);
    check("rst_pixcnt",   64'(o_pixcnt),   64'd0);
    check("rst_busy",     64'(o_busy),     64'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // D32 accumulate: 3 + 5*4 - 16 = 7
    xfer(16'd3, 0, 1, 0, 0, 0, 0, 32'd0);
    check("d32_busy_acc", 64'(o_busy), 64'd1);
    xfer(16'd5, 2, 0, 0, 0, 0, 0, 32'd0);
    xfer(16'hFFFF, 4, 0, 0, 1, 0, 0, 32'd0);
    check("d32_ppad_wr",  64'(o_ppad_write), 64'd1);
    check("d32_wdata",    64'(o_ppad_wdata), 64'd7);
    check("d32_pixcnt",   64'(o_pixcnt), 64'd1);
    check("d32_idle",     64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
    check("d32_wr_1cyc",  64'(o_ppad_write), 64'd0);

    // Pad reload: 100 + 2*2 + 0 = 104
    xfer(16'd2, 1, 0, 1, 0, 0, 0, 32'd100);
    xfer(16'd0, 0, 0, 0, 1, 0, 0, 32'd0);
    check("reload_wdata", 64'(o_ppad_wdata), 64'd104);

    // D16 saturation, both signs
    xfer(16'h4000, 1, 1, 0, 0, 0, 1, 32'd0);
    xfer(16'd1, 0, 0, 0, 1, 0, 1, 32'd0);
    check("d16_sat_pos",  64'(o_ppad_wdata), 64'h0000_7FFF);
    xfer(16'hC000, 1, 1, 0, 0, 0, 1, 32'd0);
    xfer(16'hFFFF, 0, 0, 0, 1, 0, 1, 32'd0);
    check("d16_sat_neg",  64'(o_ppad_wdata), 64'hFFFF_8000);
    check("d16_pixcnt",   64'(o_pixcnt), 64'(pix_m));

    // Last row held by downstream backpressure
    ack_force = 1'b0;
    @(posedge i_clk); #1;
    xfer(16'd42, 0, 1, 0, 1, 1, 0, 32'd0);
    check("lst_rdy",      64'(o_Out_rdy), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("lst_hold_out", 64'(o_out), 64'd42);
      check("lst_hold_ack", 64'(o_Prod_ack), 64'd0);
      check("lst_hold_busy", 64'(o_busy), 64'd1);
      @(posedge i_clk); #1;
    end
    ack_force = 1'b1;
    @(negedge i_clk);
    check("lst_ack_prod", 64'(o_Prod_ack), 64'd1);
    @(posedge i_clk); #1;
    check("lst_rdy_fall", 64'(o_Out_rdy), 64'd0);
    check("lst_prod_ack", 64'(o_Prod_ack), 64'd1);
    check("lst_idle",     64'(o_busy), 64'd0);

    // Simultaneous drain and refill
    ack_force = 1'b0;
    @(posedge i_clk); #1;
    xfer(16'd7, 0, 1, 0, 1, 1, 0, 32'd0);
    ack_force = 1'b1;
    xfer(16'd9, 0, 1, 0, 1, 1, 0, 32'd0);
    check("refill_rdy",   64'(o_Out_rdy), 64'd1);
    check("refill_out",   64'(o_out), 64'd9);
    @(posedge i_clk); #1;
    check("refill_drain", 64'(o_Out_rdy), 64'd0);

    // Reset while a final sum is pending
    ack_force = 1'b0;
    @(posedge i_clk); #1;
    xfer(16'd5, 0, 1, 0, 1, 1, 0, 32'd0);
    check("mid_rst_pre",  64'(o_Out_rdy), 64'd1);
    out_q.delete();
    acc_m = 0;
    pix_m = 0;
    #2;
    i_rst = 1'b0;
    #1;
    check("mid_rst_rdy",  64'(o_Out_rdy), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_pix",  64'(o_pixcnt), 64'd0);
    check("mid_rst_ack",  64'(o_Prod_ack), 64'd1);
    ack_force = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Randomized traffic with random downstream backpressure
    ack_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int sht;
      sht = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      xfer(16'($urandom), sht,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom);
    end
    waited = 0;
    while ((pad_q.size() != 0 || out_q.size() != 0) && waited < 200) begin
      @(posedge i_clk); #1;
      waited++;
    end
    check("final_pad_q",  64'(pad_q.size()), 64'd0);
    check("final_out_q",  64'(out_q.size()), 64'd0);
    check("final_pixcnt", 64'(o_pixcnt), 64'(pix_m % 256));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
